olive_std_core_mtimer: RTL and testbench

Parametrised multi-channel interval timer on the Avalon-MM peripheral bus of the olive standard core. Provides NCH independent down-counting channels of COUNT_W bits, each with one-shot/continuous mode, start/stop, snapshot and a sticky timeout flag. A global pending register summarises channel timeouts, and a single OR-ed `irq` output goes to the CPU interrupt controller. Optional per-channel prescaler.

---
 rtl/olive_std_core_mtimer.sv | 251 +++++++++++++++++++++++++
 tb/tb_olive_std_core_mtimer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/olive_std_core_mtimer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : olive_std_core_mtimer                                        |
// | Description : NCH-channel down-counting interval timer on an Avalon-MM     |
// |               slave. Each channel has one-shot/continuous mode, start/stop,|
// |               a snapshot register and a sticky timeout flag. A global      |
// |               PENDING register and an OR-ed irq summarise the channels.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   1   system clock                                         |
// |   reset_n    in   1   asynchronous active-low reset                        |
// |   address    in   5   [4:2] channel, [1:0] register; 5'h1C = PENDING       |
// |   chipselect in   1   slave select                                         |
// |   write_n    in   1   active-low write strobe                              |
// |   writedata  in  32   write data                                           |
// |   readdata   out 32   registered read data (latency 1, unqualified)        |
// |   irq        out  1   OR over channels of (TO && ITO)                      |
// | Registers per channel: 0 STATUS {RUN,TO}, 1 CONTROL {STOP,START,CONT,ITO}, |
// |   2 PERIOD, 3 SNAP.                                                        |
// | Build option: define MTIMER_PRESCALER_EN to add an 8-bit per-channel       |
// |   prescaler programmed through CONTROL[15:8].                              |
// +----------------------------------------------------------------------------+
module olive_std_core_mtimer #(
  parameter int unsigned NCH          = 2,
  parameter int unsigned COUNT_W      = 32,
  parameter int unsigned RESET_PERIOD = 39999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam logic [COUNT_W-1:0] RESET_VAL    = COUNT_W'(RESET_PERIOD);
  localparam logic [4:0]         PENDING_ADDR = 5'h1C;
  localparam logic [1:0]         REG_STATUS   = 2'd0;
  localparam logic [1:0]         REG_CONTROL  = 2'd1;
  localparam logic [1:0]         REG_PERIOD   = 2'd2;
  localparam logic [1:0]         REG_SNAP     = 2'd3;
  localparam int                 CTRL_ITO     = 0;
  localparam int                 CTRL_CONT    = 1;
  localparam int                 CTRL_START   = 2;
  localparam int                 CTRL_STOP    = 3;

  logic        wr_en;
  logic [2:0]  addr_ch;
  logic [1:0]  addr_reg;
  logic        addr_global;
  logic [NCH-1:0] pending;
  logic [31:0] ch_rdata [NCH];
  logic [31:0] readdata_d;
  logic [31:0] readdata_q;
  logic        unused_wdata;

  assign wr_en       = chipselect && !write_n;
  assign addr_ch     = address[4:2];
  assign addr_reg    = address[1:0];
  assign addr_global = (address == PENDING_ADDR);
  // Not every writedata bit is stored in every configuration.
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic               ch_wr;
    logic               wr_status;
    logic               wr_ctrl;
    logic               wr_period;
    logic               wr_snap;
    logic               start;
    logic               stop;
    logic               tick;
    logic               count_zero;
    logic               timeout_evt;

    logic [COUNT_W-1:0] count_q,  count_d;
    logic [COUNT_W-1:0] period_q, period_d;
    logic [COUNT_W-1:0] snap_q,   snap_d;
    logic [3:0]         ctrl_q,   ctrl_d;
    logic               run_q,    run_d;
    logic               to_q,     to_d;
    logic               reload_q, reload_d;   // force_reload, one cycle after a PERIOD write
    logic               nz_q,     nz_d;       // counter was non-zero on the previous cycle

    assign ch_wr       = wr_en && !addr_global && (addr_ch == 3'(i));
    assign wr_status   = ch_wr && (addr_reg == REG_STATUS);
    assign wr_ctrl     = ch_wr && (addr_reg == REG_CONTROL);
    assign wr_period   = ch_wr && (addr_reg == REG_PERIOD);
    assign wr_snap     = ch_wr && (addr_reg == REG_SNAP);
    assign start       = wr_ctrl && writedata[CTRL_START];
    assign stop        = wr_ctrl && writedata[CTRL_STOP];
    assign count_zero  = (count_q == '0);
    // Edge-detected so a counter parked at zero does not re-raise TO forever.
    assign timeout_evt = count_zero && nz_q;

`ifdef MTIMER_PRESCALER_EN
    logic [7:0] pre_q,     pre_d;
    logic [7:0] pre_cnt_q, pre_cnt_d;

    assign tick = run_q && (pre_cnt_q == 8'd0);

    always_comb begin
      pre_d     = pre_q;
      pre_cnt_d = pre_cnt_q;
      if (wr_ctrl) begin
        pre_d = writedata[15:8];
      end
      // START uses the PRE value arriving in the same write.
      if (start) begin
        pre_cnt_d = writedata[15:8];
      end else if (reload_q) begin
        pre_cnt_d = pre_q;
      end else if (run_q) begin
        pre_cnt_d = (pre_cnt_q == 8'd0) ? pre_q : (pre_cnt_q - 8'd1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pre_q     <= 8'd0;
        pre_cnt_q <= 8'd0;
      end else begin
        pre_q     <= pre_d;
        pre_cnt_q <= pre_cnt_d;
      end
    end
`else
    assign tick = run_q;
`endif

    always_comb begin
      count_d  = count_q;
      period_d = period_q;
      snap_d   = snap_q;
      ctrl_d   = ctrl_q;
      run_d    = run_q;
      to_d     = to_q;
      reload_d = 1'b0;
      nz_d     = !count_zero;

      if (wr_period) begin
        period_d = writedata[COUNT_W-1:0];
        reload_d = 1'b1;
      end
      if (wr_snap) begin
        snap_d = count_q;
      end
      if (wr_ctrl) begin
        ctrl_d = writedata[3:0];
      end

      // A one-shot channel parks at zero instead of reloading.
      if (reload_q) begin
        count_d = period_q;
      end else if (tick) begin
        if (count_zero) begin
          if (ctrl_q[CTRL_CONT]) begin
            count_d = period_q;
          end
        end else begin
          count_d = count_q - COUNT_W'(1);
        end
      end

      if (start) begin
        run_d = 1'b1;
      end else if (stop || reload_q) begin
        run_d = 1'b0;
      end else if (run_q && count_zero && !ctrl_q[CTRL_CONT]) begin
        run_d = 1'b0;
      end

      // A timeout landing on the same cycle as a STATUS write is not lost.
      if (timeout_evt) begin
        to_d = 1'b1;
      end else if (wr_status) begin
        to_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        count_q  <= RESET_VAL;
        period_q <= RESET_VAL;
        snap_q   <= '0;
        ctrl_q   <= 4'd0;
        run_q    <= 1'b0;
        to_q     <= 1'b0;
        reload_q <= 1'b0;
        nz_q     <= 1'b0;
      end else begin
        count_q  <= count_d;
        period_q <= period_d;
        snap_q   <= snap_d;
        ctrl_q   <= ctrl_d;
        run_q    <= run_d;
        to_q     <= to_d;
        reload_q <= reload_d;
        nz_q     <= nz_d;
      end
    end

    assign pending[i] = to_q && ctrl_q[CTRL_ITO];

    always_comb begin
      ch_rdata[i] = '0;
      case (addr_reg)
        REG_STATUS:  ch_rdata[i][1:0] = {run_q, to_q};
        REG_CONTROL: begin
          ch_rdata[i][3:0] = ctrl_q;
`ifdef MTIMER_PRESCALER_EN
          ch_rdata[i][15:8] = pre_q;
`endif
        end
        REG_PERIOD:  ch_rdata[i][COUNT_W-1:0] = period_q;
        REG_SNAP:    ch_rdata[i][COUNT_W-1:0] = snap_q;
        default:     ch_rdata[i] = '0;
      endcase
    end
  end

  // Read path samples the address every cycle, selected or not.
  always_comb begin
    readdata_d = '0;
    if (addr_global) begin
      readdata_d[NCH-1:0] = pending;
    end else begin
      for (int j = 0; j < NCH; j++) begin
        if (addr_ch == 3'(j)) begin
          readdata_d = ch_rdata[j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |pending;

endmodule
`default_nettype wire

// File: tb/tb_olive_std_core_mtimer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_olive_std_core_mtimer                                     |
// | Description : Directed self-checking bench for olive_std_core_mtimer       |
// |               (NCH=2, COUNT_W=32, RESET_PERIOD=39999).                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_olive_std_core_mtimer;

  logic        clk;
  logic        reset_n;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_fails  = 0;
  logic [31:0] rdat;

  olive_std_core_mtimer #(
    .NCH          (2),
    .COUNT_W      (32),
    .RESET_PERIOD (39999)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; consumes exactly one rising edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    @(negedge clk);
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n    = 1'b1;
    address    = 5'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;

    // ---------------- reset state ----------------
    #2 reset_n = 1'b0;
    #1;
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    idle(2);
    reset_n = 1'b1;
    rd(5'h02, rdat); chk("rst_ch0_period", rdat, 32'd39999);
    rd(5'h00, rdat); chk("rst_ch0_status", rdat, 32'd0);
    rd(5'h1C, rdat); chk("rst_pending", rdat, 32'd0);
    chk("rst_irq_after", {31'd0, irq}, 32'd0);

    // ---------------- ch1 continuous, PERIOD=4 ----------------
    wr(5'h06, 32'd4);
    wr(5'h05, 32'h7);                     // START|CONT|ITO, RUN=1 now
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("ch1_irq_before_to", {31'd0, irq}, 32'd0);
    end
    @(negedge clk);
    chk("ch1_irq_first_to", {31'd0, irq}, 32'd1);
    wr(5'h04, 32'd0);                     // clear TO
    chk("ch1_irq_cleared", {31'd0, irq}, 32'd0);
    for (int k = 7; k <= 9; k++) begin
      @(negedge clk);
      chk("ch1_irq_between", {31'd0, irq}, 32'd0);
    end
    @(negedge clk);
    chk("ch1_irq_second_to", {31'd0, irq}, 32'd1);
    rd(5'h1C, rdat); chk("ch1_pending", rdat, 32'h2);
    rd(5'h04, rdat); chk("ch1_status_to_run", rdat, 32'h3);
    wr(5'h05, 32'h8);                     // STOP, ITO off
    chk("ch1_irq_ito_off", {31'd0, irq}, 32'd0);
    wr(5'h04, 32'd0);

    // ---------------- ch0 one-shot, PERIOD=3 ----------------
    wr(5'h02, 32'd3);
    wr(5'h01, 32'h4);
    idle(6);
    rd(5'h00, rdat); chk("ch0_oneshot_status", rdat, 32'h1);
    wr(5'h03, 32'd0);
    rd(5'h03, rdat); chk("ch0_oneshot_count0", rdat, 32'd0);
    wr(5'h00, 32'd0);
    idle(8);
    rd(5'h00, rdat); chk("ch0_oneshot_single", rdat, 32'd0);

    // ---------------- snapshot and PERIOD write mid-count ----------------
    wr(5'h02, 32'd100);
    wr(5'h01, 32'h4);                     // counter = 100, RUN=1
    idle(5);                              // counter = 95
    wr(5'h03, 32'd0);
    rd(5'h03, rdat); chk("ch0_snap_95", rdat, 32'd95);
    wr(5'h02, 32'd50);
    idle(3);
    rd(5'h00, rdat); chk("ch0_reload_run0", rdat, 32'd0);
    wr(5'h03, 32'd0);
    rd(5'h03, rdat); chk("ch0_reload_count", rdat, 32'd50);

    // ---------------- STATUS write on the timeout cycle ----------------
    wr(5'h02, 32'd3);
    wr(5'h01, 32'h6);                     // CONT|START, counter = 3
    idle(3);                              // counter reaches 0
    wr(5'h00, 32'd0);                     // coincides with the timeout event
    rd(5'h00, rdat); chk("ch0_to_wins", rdat, 32'h3);
    wr(5'h01, 32'h8);
    rd(5'h00, rdat); chk("ch0_stop_run", {31'd0, rdat[1]}, 32'd0);
    wr(5'h01, 32'hC);
    rd(5'h00, rdat); chk("ch0_start_wins", {31'd0, rdat[1]}, 32'd1);
    rd(5'h01, rdat); chk("ch0_ctrl_readback", rdat, 32'hC);
    wr(5'h01, 32'h8);

    // ---------------- unimplemented channels ----------------
    wr(5'h0A, 32'd7);
    rd(5'h08, rdat); chk("ch2_status_zero", rdat, 32'd0);
    rd(5'h0A, rdat); chk("ch2_period_zero", rdat, 32'd0);
    rd(5'h1B, rdat); chk("ch6_snap_zero", rdat, 32'd0);
    rd(5'h02, rdat); chk("ch0_period_kept", rdat, 32'd3);
    rd(5'h06, rdat); chk("ch1_period_kept", rdat, 32'd4);

`ifdef MTIMER_PRESCALER_EN
    // ---------------- prescaler PRE=3, PERIOD=2 ----------------
    wr(5'h06, 32'd2);
    wr(5'h05, 32'h0307);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("pre_irq_before", {31'd0, irq}, 32'd0);
    end
    @(negedge clk);
    chk("pre_irq_first", {31'd0, irq}, 32'd1);
    wr(5'h04, 32'd0);
    chk("pre_irq_cleared", {31'd0, irq}, 32'd0);
    for (int k = 11; k <= 20; k++) begin
      @(negedge clk);
      chk("pre_irq_between", {31'd0, irq}, 32'd0);
    end
    @(negedge clk);
    chk("pre_irq_second", {31'd0, irq}, 32'd1);
    rd(5'h05, rdat); chk("pre_ctrl_readback", rdat, 32'h0307);
    wr(5'h05, 32'h8);
    wr(5'h04, 32'd0);
`else
    wr(5'h05, 32'h0302);
    rd(5'h05, rdat); chk("ctrl_pre_absent", rdat, 32'h2);
    wr(5'h05, 32'h0);
`endif

    // ---------------- asynchronous reset mid-count ----------------
    wr(5'h06, 32'd10);
    wr(5'h05, 32'h7);
    idle(3);
    address = 5'h05;
    @(negedge clk);
    chk("pre_reset_ctrl_visible", readdata, 32'h7);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_readdata", readdata, 32'd0);
    chk("async_rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(5'h06, rdat); chk("post_rst_period", rdat, 32'd39999);
    rd(5'h05, rdat); chk("post_rst_ctrl", rdat, 32'd0);
    idle(15);
    rd(5'h04, rdat); chk("post_rst_status", rdat, 32'd0);
    chk("post_rst_irq", {31'd0, irq}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
